// File: rtl/dmem_wbuf.sv
// Data memory with a store write buffer draining into a single-port word RAM.
// Optional macro DMEM_FWD_EN: forward buffered stores to loads instead of stalling.
module dmem_wbuf #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   memCe,
    input  logic                   memWr,
    input  logic [31:0]            memAddr,
    input  logic [31:0]            wtData,
    output logic [31:0]            rdData,
    output logic                   stall,
    output logic [$clog2(DEPTH):0] wbufCount
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] buf_idx_q  [DEPTH];
    logic [ADDR_W-1:0] buf_idx_d  [DEPTH];
    logic [31:0]       buf_data_q [DEPTH];
    logic [31:0]       buf_data_d [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic [31:0]       mem [2**ADDR_W];

    logic [ADDR_W-1:0] idx;
    logic              load_req, store_req, full;
    logic              hit;
    logic [31:0]       hit_data;
    logic              enq, drain;
    logic              unused_addr_bits;

    assign idx              = memAddr[ADDR_W+1:2];
    assign unused_addr_bits = ^{memAddr[31:ADDR_W+2], memAddr[1:0]};
    assign load_req         = memCe & ~memWr;
    assign store_req        = memCe & memWr;
    assign full             = (count_q == CW'(DEPTH));

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count_q && buf_idx_q[PW'(head_q + PW'(k))] == idx) begin
                hit      = 1'b1;
                hit_data = buf_data_q[PW'(head_q + PW'(k))];
            end
        end
    end

    always_comb begin
        stall  = 1'b0;
        rdData = '0;
        if (!rst) begin
`ifdef DMEM_FWD_EN
            stall = store_req & full;
            if (load_req)
                rdData = hit ? hit_data : mem[idx];
`else
            stall = (store_req & full) | (load_req & hit);
            if (load_req && !hit)
                rdData = mem[idx];
`endif
        end
    end

    // Only an accepted load owns the RAM port; a stalled load lets the drain proceed.
    assign enq   = ~rst & store_req & ~full;
    assign drain = ~rst & (count_q != '0) & ~(load_req & ~stall);

    assign wbufCount = rst ? '0 : count_q;

    always_comb begin
        buf_idx_d  = buf_idx_q;
        buf_data_d = buf_data_q;
        head_d     = head_q + PW'(drain);
        tail_d     = tail_q + PW'(enq);
        count_d    = count_q + CW'(enq) - CW'(drain);
        if (enq) begin
            buf_idx_d[tail_q]  = idx;
            buf_data_d[tail_q] = wtData;
        end
        if (rst) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        head_q     <= head_d;
        tail_q     <= tail_d;
        count_q    <= count_d;
        buf_idx_q  <= buf_idx_d;
        buf_data_q <= buf_data_d;
    end

    always_ff @(posedge clk) begin
        if (drain)
            mem[buf_idx_q[head_q]] <= buf_data_q[head_q];
    end

endmodule
